// File: rtl/detect_event_counter_pkg.sv
// Shared types and default widths for the detection event counter.
package detect_event_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned WIN_W_DEF = 8;

endpackage

// File: rtl/rpt_hold_reg.sv
// Valid/ready holding register for one window report, with sticky overrun on drop.
module rpt_hold_reg
  import detect_event_counter_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIN_W-1:0] count_i,
  input  logic             alarm_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIN_W-1:0] count_o,
  output logic             alarm_o,
  output logic             overrun_o
);

  logic             valid_q, valid_d;
  logic [WIN_W-1:0] count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             overrun_q, overrun_d;
  logic             handshake_c;

  // A close coinciding with a handshake refills the slot instead of dropping.
  always_comb begin
    valid_d     = valid_q;
    count_d     = count_q;
    alarm_d     = alarm_q;
    overrun_d   = overrun_q;
    handshake_c = valid_q && ready_i;
    if (clear_i) begin
      valid_d   = 1'b0;
      count_d   = '0;
      alarm_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (handshake_c) valid_d = 1'b0;
      if (load_i) begin
        if (!valid_q || handshake_c) begin
          valid_d = 1'b1;
          count_d = count_i;
          alarm_d = alarm_i;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      count_q   <= '0;
      alarm_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      alarm_q   <= alarm_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign count_o   = count_q;
  assign alarm_o   = alarm_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/detect_event_counter.sv
// Counts detector hits into a saturating total and per-window reports with alarm.
module detect_event_counter
  import detect_event_counter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned WIN_W = WIN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             valid_i,
  input  logic             pattern_detected_i,
  input  logic             clear_i,
  input  logic [WIN_W-1:0] window_len_i,
  input  logic [WIN_W-1:0] threshold_i,
  output logic [CNT_W-1:0] total_count_o,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [WIN_W-1:0] rpt_count_o,
  output logic             rpt_alarm_o,
  output logic             overrun_o
);

  localparam int unsigned SMP_W = WIN_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [WIN_W-1:0] len_q, len_d;

  logic             run_c, det_c, sample_c, close_c, load_c, alarm_c, stop_c;
  logic [WIN_W-1:0] len_cur_c, win_next_c;
  logic [SMP_W-1:0] len_eff_c, smp_next_c;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable_i)  state_d = RUN;
      RUN:  if (!enable_i) state_d = IDLE;
    endcase
  end

  // Window length is taken live on the first sample, latched for the rest.
  always_comb begin
    run_c      = (state_q == RUN) && enable_i;
    stop_c     = (state_q == RUN) && !enable_i;
    det_c      = run_c && pattern_detected_i;
    sample_c   = run_c && valid_i;
    len_cur_c  = (smp_cnt_q == '0) ? window_len_i : len_q;
    len_eff_c  = (len_cur_c == '0) ? {1'b1, {WIN_W{1'b0}}} : SMP_W'(len_cur_c);
    smp_next_c = SMP_W'(smp_cnt_q) + SMP_W'(1);
    close_c    = sample_c && (smp_next_c == len_eff_c);
    win_next_c = (det_c && (win_cnt_q != '1)) ? win_cnt_q + WIN_W'(1) : win_cnt_q;
    alarm_c    = (win_next_c >= threshold_i);
    load_c     = close_c && !clear_i;

    total_d   = (det_c && (total_q != '1)) ? total_q + CNT_W'(1) : total_q;
    win_cnt_d = win_next_c;
    smp_cnt_d = sample_c ? WIN_W'(smp_next_c) : smp_cnt_q;
    len_d     = (sample_c && (smp_cnt_q == '0)) ? window_len_i : len_q;

    if (close_c || stop_c) begin
      win_cnt_d = '0;
      smp_cnt_d = '0;
    end
    if (clear_i) begin
      total_d   = '0;
      win_cnt_d = '0;
      smp_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      total_q   <= '0;
      win_cnt_q <= '0;
      smp_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      total_q   <= total_d;
      win_cnt_q <= win_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      len_q     <= len_d;
    end
  end

  assign total_count_o = total_q;

  rpt_hold_reg #(
    .WIN_W (WIN_W)
  ) u_rpt_hold_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .load_i    (load_c),
    .count_i   (win_next_c),
    .alarm_i   (alarm_c),
    .ready_i   (rpt_ready_i),
    .valid_o   (rpt_valid_o),
    .count_o   (rpt_count_o),
    .alarm_o   (rpt_alarm_o),
    .overrun_o (overrun_o)
  );

endmodule

// File: tb/tb_detect_event_counter.sv
// Scoreboard bench: stimulus queues expected reports/status, a monitor compares them.
module tb_detect_event_counter;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned WIN_W = 8;

  typedef struct {
    logic [WIN_W-1:0] count;
    logic             alarm;
  } rpt_t;

  typedef struct {
    string            name;
    logic [CNT_W-1:0] total;
    logic             rv;
    logic [WIN_W-1:0] rc;
    logic             ra;
    logic             ov;
    bit               chk_rpt;
  } st_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             valid = 1'b0;
  logic             det = 1'b0;
  logic             clear = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [WIN_W-1:0] thresh = '0;
  logic             ready = 1'b0;
  logic [CNT_W-1:0] total;
  logic             rpt_valid;
  logic [WIN_W-1:0] rpt_count;
  logic             rpt_alarm;
  logic             overrun;

  rpt_t rq[$];
  st_t  sq[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  detect_event_counter #(
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .enable_i           (enable),
    .valid_i            (valid),
    .pattern_detected_i (det),
    .clear_i            (clear),
    .window_len_i       (win_len),
    .threshold_i        (thresh),
    .total_count_o      (total),
    .rpt_valid_o        (rpt_valid),
    .rpt_ready_i        (ready),
    .rpt_count_o        (rpt_count),
    .rpt_alarm_o        (rpt_alarm),
    .overrun_o          (overrun)
  );

  // One clock of stimulus; inputs return to idle afterwards.
  task automatic cyc(input bit v, input bit d, input bit c, input bit r);
    valid = v;
    det   = d;
    clear = c;
    ready = r;
    @(posedge clk);
    #1;
    valid = 1'b0;
    det   = 1'b0;
    clear = 1'b0;
    ready = 1'b0;
  endtask

  task automatic exp_rpt(input int cnt, input bit alm);
    rpt_t e;
    e.count = WIN_W'(cnt);
    e.alarm = alm;
    rq.push_back(e);
  endtask

  task automatic exp_st(input string name, input int tot, input bit rv, input int rc,
                        input bit ra, input bit ov, input bit chk_rpt);
    st_t s;
    s.name    = name;
    s.total   = CNT_W'(tot);
    s.rv      = rv;
    s.rc      = WIN_W'(rc);
    s.ra      = ra;
    s.ov      = ov;
    s.chk_rpt = chk_rpt;
    sq.push_back(s);
  endtask

  // Monitor: all comparisons happen here on the falling edge.
  initial begin : monitor
    rpt_t e;
    st_t  s;
    bit   bad;
    forever begin
      @(negedge clk);
      if (rst_n && rpt_valid && ready) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_report: got count=%0d alarm=%0d, none expected", rpt_count, rpt_alarm);
        end else begin
          e = rq.pop_front();
          if (rpt_count !== e.count || rpt_alarm !== e.alarm) begin
            errors++;
            $display("FAIL report: got count=%0d alarm=%0d, expected count=%0d alarm=%0d",
                     rpt_count, rpt_alarm, e.count, e.alarm);
          end
        end
      end
      if (sq.size() != 0) begin
        s = sq.pop_front();
        checks++;
        bad = (total !== s.total) || (rpt_valid !== s.rv) || (overrun !== s.ov);
        if (s.chk_rpt || s.rv) bad = bad || (rpt_count !== s.rc) || (rpt_alarm !== s.ra);
        if (bad) begin
          errors++;
          $display("FAIL %s: got total=%0d rv=%0d rc=%0d ra=%0d ov=%0d, expected total=%0d rv=%0d rc=%0d ra=%0d ov=%0d",
                   s.name, total, rpt_valid, rpt_count, rpt_alarm, overrun,
                   s.total, s.rv, s.rc, s.ra, s.ov);
        end
      end
      if (done && sq.size() == 0) begin
        checks++;
        if (rq.size() != 0) begin
          errors++;
          $display("FAIL missing_reports: got %0d outstanding, expected 0", rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    exp_st("reset", 0, 0, 0, 0, 0, 1);
    enable = 1'b1;
    cyc(0, 0, 0, 0);

    // Basic window: len 4, detections on samples 2 and 4.
    win_len = 8'd4;
    thresh  = 8'd2;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    exp_st("basic_window", 2, 1, 2, 1, 0, 1);
    exp_rpt(2, 1);
    cyc(0, 0, 0, 1);
    exp_st("basic_handshake", 2, 0, 0, 0, 0, 0);

    // Two windows without ready: second report dropped, overrun set.
    cyc(0, 0, 1, 0);
    exp_st("clear", 0, 0, 0, 0, 0, 0);
    win_len = 8'd3;
    thresh  = 8'd1;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    exp_st("first_window", 1, 1, 1, 1, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    exp_st("overrun_hold", 3, 1, 1, 1, 1, 1);
    exp_rpt(1, 1);
    cyc(0, 0, 0, 1);
    exp_st("overrun_sticky", 3, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    exp_st("no_second_report", 3, 0, 0, 0, 1, 0);

    // Clear coinciding with a closing detection.
    cyc(0, 0, 1, 0);
    win_len = 8'd2;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    exp_st("clear_vs_close", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    exp_st("post_clear_window", 1, 1, 1, 1, 0, 1);
    exp_rpt(1, 1);
    cyc(0, 0, 0, 1);

    // Close in the same cycle as a handshake keeps valid high.
    win_len = 8'd1;
    cyc(1, 1, 0, 0);
    exp_st("len1_window", 2, 1, 1, 1, 0, 1);
    exp_rpt(1, 1);
    exp_rpt(0, 0);
    cyc(1, 0, 0, 1);
    exp_st("close_with_handshake", 2, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    exp_st("refill_drained", 2, 0, 0, 0, 0, 0);

    // Total saturates at 15 for a 4-bit counter.
    cyc(0, 0, 1, 0);
    repeat (20) cyc(0, 1, 0, 0);
    exp_st("total_saturate", 15, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Reset mid-window discards the partial window.
    win_len = 8'd4;
    thresh  = 8'd3;
    repeat (3) cyc(1, 1, 0, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    exp_st("mid_window_reset", 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    exp_st("idle_no_count", 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    exp_st("post_reset_window", 1, 1, 1, 0, 0, 1);
    exp_rpt(1, 0);

    // Handshake still completes while idle; detections ignored.
    enable = 1'b0;
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    exp_st("idle_handshake", 1, 0, 0, 0, 0, 0);
    enable = 1'b1;
    cyc(0, 0, 0, 0);

    // Length 0 means 256 samples; mid-window length change is deferred.
    cyc(0, 0, 1, 0);
    win_len = 8'd0;
    thresh  = 8'd1;
    cyc(1, 0, 0, 0);
    win_len = 8'd5;
    repeat (254) cyc(1, 0, 0, 0);
    exp_st("len0_sample255", 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    exp_st("len0_sample256", 1, 1, 1, 1, 0, 1);
    exp_rpt(1, 1);
    cyc(0, 0, 0, 1);
    exp_st("len0_drained", 1, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0);
    done = 1'b1;
  end

endmodule
